// File: rtl/loader_pkg.sv
// Shared definitions for the F100-L program loader: FSM encodings and frame constants.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECKSUM
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;
  localparam logic [7:0] CSUM_GOOD         = 8'h00;
  localparam int         LEN_WIDTH         = 16;

  // The checksum byte closes the running sum of length and data bytes to zero.
  function automatic logic csum_ok(input logic [7:0] acc, input logic [7:0] last);
    return 8'(acc + last) == CSUM_GOOD;
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: counts idle cycles inside a frame, pulses expire on the limit.
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // A byte arriving in the limit cycle still counts as in time.
  assign expire = enable && !clear && (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || clear || !enable || expire) count <= '0;
    else                                     count <= count + CW'(1);
  end

endmodule

// File: rtl/program_loader.sv
// Program RAM writer: parses framed byte stream, writes 16-bit words, halts core during load.
module program_loader
  import loader_pkg::*;
#(
  parameter int              ADDR_WIDTH     = 10,
  parameter logic [7:0]      SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int unsigned     TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [15:0]           mem_data_out,
  output logic                  mem_write_enable,
  output logic                  cpu_halt,
  output logic                  load_done,
  output logic                  load_error
);

  localparam logic [LEN_WIDTH:0] MAX_WORDS = (LEN_WIDTH+1)'(1) << ADDR_WIDTH;

  state_t                state, next_state;
  logic [7:0]            byte_latch;
  logic [7:0]            csum;
  logic [ADDR_WIDTH:0]   word_idx;
  logic [ADDR_WIDTH:0]   len_words;
  logic [LEN_WIDTH-1:0]  len_full;
  logic                  len_bad, len_zero, last_word;
  logic                  start, wr, len_err, fin, fin_ok, fail, expire;

  assign len_full  = {byte_latch, rx_data};
  assign len_bad   = (LEN_WIDTH+1)'(len_full) > MAX_WORDS;
  assign len_zero  = (len_full == '0);
  assign last_word = (word_idx + (ADDR_WIDTH+1)'(1)) == len_words;

  loader_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .enable (state != S_IDLE),
    .clear  (rx_valid),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (expire) next_state = S_IDLE;
    else if (rx_valid) begin
      unique case (state)
        S_IDLE:     if (rx_data == SYNC_BYTE) next_state = S_LEN_HI;
        S_LEN_HI:   next_state = S_LEN_LO;
        S_LEN_LO:   next_state = len_zero ? S_CHECKSUM : (len_bad ? S_IDLE : S_DATA_HI);
        S_DATA_HI:  next_state = S_DATA_LO;
        S_DATA_LO:  next_state = last_word ? S_CHECKSUM : S_DATA_HI;
        S_CHECKSUM: next_state = S_IDLE;
        default:    next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    start   = (state == S_IDLE) && rx_valid && (rx_data == SYNC_BYTE);
    wr      = (state == S_DATA_LO) && rx_valid;
    len_err = (state == S_LEN_LO) && rx_valid && len_bad;
    fin     = (state == S_CHECKSUM) && rx_valid;
    fin_ok  = fin && csum_ok(csum, rx_data);
    fail    = len_err || (fin && !fin_ok) || expire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_address      <= '0;
      mem_data_out     <= '0;
      mem_write_enable <= 1'b0;
      cpu_halt         <= 1'b0;
      load_done        <= 1'b0;
      load_error       <= 1'b0;
      byte_latch       <= '0;
      csum             <= '0;
      word_idx         <= '0;
      len_words        <= '0;
    end else begin
      mem_write_enable <= wr;
      if (rx_valid && state != S_IDLE) csum <= csum + rx_data;
      if (rx_valid && (state == S_LEN_HI || state == S_DATA_HI)) byte_latch <= rx_data;
      if (rx_valid && state == S_LEN_LO) len_words <= len_full[ADDR_WIDTH:0];
      if (wr) begin
        mem_address  <= word_idx[ADDR_WIDTH-1:0];
        mem_data_out <= {byte_latch, rx_data};
        word_idx     <= word_idx + (ADDR_WIDTH+1)'(1);
      end
      if (start) begin
        cpu_halt   <= 1'b1;
        load_done  <= 1'b0;
        load_error <= 1'b0;
        word_idx   <= '0;
        csum       <= '0;
      end
      if (fin_ok) begin
        load_done <= 1'b1;
        cpu_halt  <= 1'b0;
      end
      if (fail) begin
        load_error <= 1'b1;
        cpu_halt   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed vector bench for program_loader: one byte (or idle) per clock, outputs checked after each edge.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [9:0]  mem_address;
  logic [15:0] mem_data_out;
  logic        mem_write_enable, cpu_halt, load_done, load_error;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  program_loader #(.ADDR_WIDTH(10), .SYNC_BYTE(8'h55), .TIMEOUT_CYCLES(100)) dut (
    .clk              (clk),
    .reset            (reset),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .mem_address      (mem_address),
    .mem_data_out     (mem_data_out),
    .mem_write_enable (mem_write_enable),
    .cpu_halt         (cpu_halt),
    .load_done        (load_done),
    .load_error       (load_error)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [7:0]  d;
    logic        we;
    logic [9:0]  a;
    logic [15:0] wd;
    logic        h, dn, er;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic vld, input logic [7:0] d, input logic we,
                     input logic [9:0] a, input logic [15:0] wd,
                     input logic h, input logic dn, input logic er);
    vec_t v;
    v.rst = rst; v.vld = vld; v.d = d; v.we = we; v.a = a; v.wd = wd;
    v.h = h; v.dn = dn; v.er = er;
    tbl.push_back(v);
  endtask

  // Drive one cycle of input, then check the registered outputs just after the edge.
  task automatic apply(input vec_t v, input string name);
    reset    = v.rst;
    rx_valid = v.vld;
    rx_data  = v.d;
    @(posedge clk);
    #1;
    n_vec++;
    if ({mem_write_enable, mem_address, mem_data_out, cpu_halt, load_done, load_error} !==
        {v.we, v.a, v.wd, v.h, v.dn, v.er}) begin
      n_bad++;
      $display("FAIL %s: got we=%0b addr=%h data=%h halt=%0b done=%0b err=%0b, want we=%0b addr=%h data=%h halt=%0b done=%0b err=%0b",
               name, mem_write_enable, mem_address, mem_data_out, cpu_halt, load_done, load_error,
               v.we, v.a, v.wd, v.h, v.dn, v.er);
    end
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;

    //   rst vld data  we  addr    wdata     halt done err
    add(1, 0, 8'h00, 0, 10'h000, 16'h0000, 0, 0, 0);   // reset state
    // good frame, back to back: 00+02+12+34+AB+CD = C0, so 40 closes the sum
    add(0, 1, 8'h55, 0, 10'h000, 16'h0000, 1, 0, 0);
    add(0, 1, 8'h00, 0, 10'h000, 16'h0000, 1, 0, 0);
    add(0, 1, 8'h02, 0, 10'h000, 16'h0000, 1, 0, 0);
    add(0, 1, 8'h12, 0, 10'h000, 16'h0000, 1, 0, 0);
    add(0, 1, 8'h34, 1, 10'h000, 16'h1234, 1, 0, 0);
    add(0, 1, 8'hAB, 0, 10'h000, 16'h1234, 1, 0, 0);
    add(0, 1, 8'hCD, 1, 10'h001, 16'hABCD, 1, 0, 0);
    add(0, 1, 8'h40, 0, 10'h001, 16'hABCD, 0, 1, 0);
    add(0, 0, 8'h00, 0, 10'h001, 16'hABCD, 0, 1, 0);   // done held
    // same frame, bad checksum 33
    add(0, 1, 8'h55, 0, 10'h001, 16'hABCD, 1, 0, 0);
    add(0, 1, 8'h00, 0, 10'h001, 16'hABCD, 1, 0, 0);
    add(0, 1, 8'h02, 0, 10'h001, 16'hABCD, 1, 0, 0);
    add(0, 1, 8'h12, 0, 10'h001, 16'hABCD, 1, 0, 0);
    add(0, 1, 8'h34, 1, 10'h000, 16'h1234, 1, 0, 0);
    add(0, 1, 8'hAB, 0, 10'h000, 16'h1234, 1, 0, 0);
    add(0, 1, 8'hCD, 1, 10'h001, 16'hABCD, 1, 0, 0);
    add(0, 1, 8'h33, 0, 10'h001, 16'hABCD, 0, 0, 1);
    // zero-length frame
    add(0, 1, 8'h55, 0, 10'h001, 16'hABCD, 1, 0, 0);
    add(0, 1, 8'h00, 0, 10'h001, 16'hABCD, 1, 0, 0);
    add(0, 1, 8'h00, 0, 10'h001, 16'hABCD, 1, 0, 0);
    add(0, 1, 8'h00, 0, 10'h001, 16'hABCD, 0, 1, 0);
    // LEN = 0x0401 exceeds 1024 words
    add(0, 1, 8'h55, 0, 10'h001, 16'hABCD, 1, 0, 0);
    add(0, 1, 8'h04, 0, 10'h001, 16'hABCD, 1, 0, 0);
    add(0, 1, 8'h01, 0, 10'h001, 16'hABCD, 0, 0, 1);
    add(0, 1, 8'h12, 0, 10'h001, 16'hABCD, 0, 0, 1);   // back in IDLE, ignored
    // leading junk, SYNC value as data; 01+55+55+55 = 100
    add(0, 1, 8'h00, 0, 10'h001, 16'hABCD, 0, 0, 1);
    add(0, 1, 8'hFF, 0, 10'h001, 16'hABCD, 0, 0, 1);
    add(0, 1, 8'h55, 0, 10'h001, 16'hABCD, 1, 0, 0);
    add(0, 1, 8'h00, 0, 10'h001, 16'hABCD, 1, 0, 0);
    add(0, 1, 8'h01, 0, 10'h001, 16'hABCD, 1, 0, 0);
    add(0, 1, 8'h55, 0, 10'h001, 16'hABCD, 1, 0, 0);
    add(0, 1, 8'h55, 1, 10'h000, 16'h5555, 1, 0, 0);
    add(0, 1, 8'h55, 0, 10'h000, 16'h5555, 0, 1, 0);
    // LEN = 0x0400 is exactly the RAM size and is accepted; reset lands on a DATA_LO byte
    add(0, 1, 8'h55, 0, 10'h000, 16'h5555, 1, 0, 0);
    add(0, 1, 8'h04, 0, 10'h000, 16'h5555, 1, 0, 0);
    add(0, 1, 8'h00, 0, 10'h000, 16'h5555, 1, 0, 0);
    add(0, 1, 8'h12, 0, 10'h000, 16'h5555, 1, 0, 0);
    add(1, 1, 8'h34, 0, 10'h000, 16'h0000, 0, 0, 0);
    add(0, 0, 8'h00, 0, 10'h000, 16'h0000, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Timeout: frame stalls after DATA_HI; error exactly 100 cycles after the last byte.
    v.rst = 0; v.we = 0; v.a = 10'h000; v.wd = 16'h0000; v.dn = 0; v.er = 0; v.h = 1;
    v.vld = 1; v.d = 8'h55; apply(v, "tmo_sync");
    v.d = 8'h00;            apply(v, "tmo_lenhi");
    v.d = 8'h01;            apply(v, "tmo_lenlo");
    v.d = 8'h12;            apply(v, "tmo_datahi");
    v.vld = 0; v.d = 8'h00;
    for (int i = 1; i < 100; i++) apply(v, $sformatf("tmo_wait%0d", i));
    v.h = 0; v.er = 1;      apply(v, "tmo_expire");
    v.vld = 1; v.d = 8'h34; apply(v, "tmo_late_byte");   // no write after abort

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
